// File: rtl/logic_sweep_checker.sv
// Self-sequencing bitwise-function checker: sweeps every (a,b) pair and compares a
// NAND-only structural network against a behavioural expression, counting mismatches.
module nand2_cell (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);
   assign y_o = ~(a_i & b_i);
endmodule

// One result bit built from 2-input NAND cells only; op picks which network output is used.
module lsc_nand_lane (
   input  logic       a_i,
   input  logic       b_i,
   input  logic [2:0] op_i,
   output logic       y_o
);
   logic na, nb, nab, y_and, y_or, y_nor, xa, xb, y_xor, y_xnor, y_f6, y_f7;

   nand2_cell u_na   (.a_i(a_i),   .b_i(a_i),   .y_o(na));
   nand2_cell u_nb   (.a_i(b_i),   .b_i(b_i),   .y_o(nb));
   nand2_cell u_ab   (.a_i(a_i),   .b_i(b_i),   .y_o(nab));
   nand2_cell u_and  (.a_i(nab),   .b_i(nab),   .y_o(y_and));
   nand2_cell u_or   (.a_i(na),    .b_i(nb),    .y_o(y_or));
   nand2_cell u_nor  (.a_i(y_or),  .b_i(y_or),  .y_o(y_nor));
   nand2_cell u_xa   (.a_i(a_i),   .b_i(nab),   .y_o(xa));
   nand2_cell u_xb   (.a_i(b_i),   .b_i(nab),   .y_o(xb));
   nand2_cell u_xor  (.a_i(xa),    .b_i(xb),    .y_o(y_xor));
   nand2_cell u_xnor (.a_i(y_xor), .b_i(y_xor), .y_o(y_xnor));
   nand2_cell u_f6   (.a_i(a_i),   .b_i(nb),    .y_o(y_f6));
   nand2_cell u_f7   (.a_i(na),    .b_i(b_i),   .y_o(y_f7));

   always_comb begin
      y_o = 1'b0;
      case (op_i)
         3'd0: y_o = y_and;
         3'd1: y_o = y_or;
         3'd2: y_o = nab;
         3'd3: y_o = y_nor;
         3'd4: y_o = y_xor;
         3'd5: y_o = y_xnor;
         3'd6: y_o = y_f6;
         3'd7: y_o = y_f7;
         default: y_o = 1'b0;
      endcase
   end
endmodule

module logic_sweep_checker #(
   parameter int N = 4
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           start_i,
   input  logic           abort_i,
   input  logic [2:0]     op_i,
   input  logic           inj_en_i,
   input  logic [2*N-1:0] inj_vec_i,
   output logic           busy_o,
   output logic           done_o,
   output logic [N-1:0]   cur_a_o,
   output logic [N-1:0]   cur_b_o,
   output logic [N-1:0]   cur_y_o,
   output logic [2*N:0]   mismatch_cnt_o,
   output logic           fail_valid_o,
   output logic [2*N-1:0] first_fail_o
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q;
   logic [2*N-1:0] v_q, inj_vec_q, first_fail_q;
   logic [2:0]     op_q;
   logic           inj_en_q, busy_q, done_q, fail_valid_q;
   logic [2*N:0]   cnt_q;

   logic [N-1:0]   a, b, y_beh, y_nand, y_str, inj_mask;
   logic           mismatch;

   assign a = v_q[2*N-1:N];
   assign b = v_q[N-1:0];

   for (genvar i = 0; i < N; i++) begin : g_lane
      lsc_nand_lane u_lane (.a_i(a[i]), .b_i(b[i]), .op_i(op_q), .y_o(y_nand[i]));
   end

   always_comb begin
      y_beh = '0;
      case (op_q)
         3'd0: y_beh = a & b;
         3'd1: y_beh = a | b;
         3'd2: y_beh = ~(a & b);
         3'd3: y_beh = ~(a | b);
         3'd4: y_beh = a ^ b;
         3'd5: y_beh = ~(a ^ b);
         3'd6: y_beh = ~(a & ~b);
         3'd7: y_beh = ~(~a & b);
         default: y_beh = '0;
      endcase
   end

   // Fault injection flips only bit 0 of the structural result on the chosen vector.
   always_comb begin
      inj_mask    = '0;
      inj_mask[0] = inj_en_q && (v_q == inj_vec_q);
   end

   assign y_str    = y_nand ^ inj_mask;
   assign mismatch = (y_str != y_beh);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         v_q          <= '0;
         op_q         <= '0;
         inj_en_q     <= 1'b0;
         inj_vec_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cnt_q        <= '0;
         fail_valid_q <= 1'b0;
         first_fail_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  op_q         <= op_i;
                  inj_en_q     <= inj_en_i;
                  inj_vec_q    <= inj_vec_i;
                  v_q          <= '0;
                  cnt_q        <= '0;
                  fail_valid_q <= 1'b0;
                  first_fail_q <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= RUN;
               end
            end
            RUN: begin
               if (abort_i) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  if (mismatch) begin
                     cnt_q <= cnt_q + {{(2*N){1'b0}}, 1'b1};
                     if (!fail_valid_q) begin
                        first_fail_q <= v_q;
                        fail_valid_q <= 1'b1;
                     end
                  end
                  v_q <= v_q + {{(2*N-1){1'b0}}, 1'b1};
                  if (v_q == '1) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign cur_a_o        = a;
   assign cur_b_o        = b;
   assign cur_y_o        = y_beh;
   assign mismatch_cnt_o = cnt_q;
   assign fail_valid_o   = fail_valid_q;
   assign first_fail_o   = first_fail_q;
endmodule

// File: tb/tb_logic_sweep_checker.sv
// Directed bench for logic_sweep_checker: N=4 and N=1 instances, hand-computed expectations.
module tb_logic_sweep_checker;
   logic clk, rst_n;

   logic       start, abort, inj_en, busy, done, fail_valid;
   logic [2:0] op;
   logic [7:0] inj_vec, first_fail;
   logic [3:0] cur_a, cur_b, cur_y;
   logic [8:0] mcnt;

   logic       start1, abort1, inj_en1, busy1, done1, fail_valid1;
   logic [2:0] op1;
   logic [1:0] inj_vec1, first_fail1;
   logic [0:0] cur_a1, cur_b1, cur_y1;
   logic [2:0] mcnt1;

   int checks = 0;
   int errors = 0;

   logic_sweep_checker #(.N(4)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .op_i(op),
      .inj_en_i(inj_en), .inj_vec_i(inj_vec), .busy_o(busy), .done_o(done),
      .cur_a_o(cur_a), .cur_b_o(cur_b), .cur_y_o(cur_y), .mismatch_cnt_o(mcnt),
      .fail_valid_o(fail_valid), .first_fail_o(first_fail));

   logic_sweep_checker #(.N(1)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .abort_i(abort1), .op_i(op1),
      .inj_en_i(inj_en1), .inj_vec_i(inj_vec1), .busy_o(busy1), .done_o(done1),
      .cur_a_o(cur_a1), .cur_b_o(cur_b1), .cur_y_o(cur_y1), .mismatch_cnt_o(mcnt1),
      .fail_valid_o(fail_valid1), .first_fail_o(first_fail1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic start4(input logic [2:0] o, input logic ie, input logic [7:0] iv);
      @(negedge clk);
      op = o; inj_en = ie; inj_vec = iv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns number of busy cycles seen from the current (first RUN) negedge, and done at exit.
   task automatic wait_done(input int limit, output int ncyc, output logic d);
      ncyc = 0;
      while (busy === 1'b1 && ncyc < limit) begin
         ncyc++;
         @(negedge clk);
      end
      d = done;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 0; abort = 0; op = 0; inj_en = 0; inj_vec = 0;
      start1 = 0; abort1 = 0; op1 = 0; inj_en1 = 0; inj_vec1 = 0;
      #1;
      checks++;
      if ({busy, done, fail_valid, mcnt, first_fail, cur_a, cur_b, cur_y} !== '0) begin
         errors++;
         $display("FAIL reset4: busy=%b done=%b fv=%b cnt=%0d ff=%h a=%h b=%h y=%h, required all 0",
                  busy, done, fail_valid, mcnt, first_fail, cur_a, cur_b, cur_y);
      end
      checks++;
      if ({busy1, done1, fail_valid1, mcnt1, first_fail1, cur_a1, cur_b1, cur_y1} !== '0) begin
         errors++;
         $display("FAIL reset1: busy=%b done=%b cnt=%0d y=%b, required all 0", busy1, done1, mcnt1, cur_y1);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_clean_sweep;
      int n; logic d;
      start4(3'd6, 1'b0, 8'h00);
      wait_done(400, n, d);
      checks++;
      if (n !== 256 || d !== 1'b1) begin
         errors++; $display("FAIL clean_len: busy_cycles=%0d done=%b, required 256 and 1", n, d);
      end
      checks++;
      if (mcnt !== 9'd0 || fail_valid !== 1'b0) begin
         errors++; $display("FAIL clean_cnt: cnt=%0d fv=%b, required 0 and 0", mcnt, fail_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL clean_pulse: done=%b busy=%b after done cycle, required 0 0", done, busy);
      end
   endtask

   task automatic test_inject;
      int n; logic d; logic [11:0] probe;
      start4(3'd4, 1'b1, 8'h5A);
      n = 0; probe = 'x;
      while (busy === 1'b1 && n < 400) begin
         if (n == 8'h5A) probe = {cur_a, cur_b, cur_y};
         n++;
         @(negedge clk);
      end
      d = done;
      checks++;
      if (probe !== 12'h5AF) begin
         errors++; $display("FAIL inj_probe: a/b/y=%h, required 5af", probe);
      end
      checks++;
      if (n !== 256 || d !== 1'b1) begin
         errors++; $display("FAIL inj_len: busy_cycles=%0d done=%b, required 256 and 1", n, d);
      end
      checks++;
      if (mcnt !== 9'd1 || fail_valid !== 1'b1 || first_fail !== 8'h5A) begin
         errors++; $display("FAIL inj_result: cnt=%0d fv=%b ff=%h, required 1 1 5a", mcnt, fail_valid, first_fail);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (mcnt !== 9'd1 || first_fail !== 8'h5A) begin
         errors++; $display("FAIL inj_hold: cnt=%0d ff=%h, required 1 5a", mcnt, first_fail);
      end
   endtask

   task automatic test_n1_nand;
      int n; logic [3:0] ys;
      @(negedge clk);
      op1 = 3'd2; inj_en1 = 0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0; ys = '0;
      while (busy1 === 1'b1 && n < 20) begin
         if (n < 4) ys[3-n] = cur_y1[0];
         n++;
         @(negedge clk);
      end
      checks++;
      if (ys !== 4'b1110) begin
         errors++; $display("FAIL n1_yseq: seq=%b, required 1110", ys);
      end
      checks++;
      if (n !== 4 || done1 !== 1'b1 || mcnt1 !== 3'd0) begin
         errors++; $display("FAIL n1_done: cycles=%0d done=%b cnt=%0d, required 4 1 0", n, done1, mcnt1);
      end
   endtask

   task automatic test_start_ignored;
      int n; logic [3:0] y150;
      start4(3'd6, 1'b0, 8'h00);
      n = 0; y150 = 'x;
      while (busy === 1'b1 && n < 400) begin
         // Retrigger with different settings; a relatch would restart v and inject at F0.
         if (n == 10 || n == 100) begin op = 3'd4; inj_en = 1; inj_vec = 8'hF0; start = 1; end
         else start = 0;
         if (n == 150) y150 = cur_y;
         n++;
         @(negedge clk);
      end
      start = 0;
      checks++;
      if (n !== 256 || done !== 1'b1) begin
         errors++; $display("FAIL restart_len: busy_cycles=%0d done=%b, required 256 and 1", n, done);
      end
      checks++;
      if (y150 !== 4'h6 || mcnt !== 9'd0) begin
         errors++; $display("FAIL restart_op: y@150=%h cnt=%0d, required 6 and 0", y150, mcnt);
      end
   endtask

   task automatic test_abort;
      int n; int dseen; logic d;
      start4(3'd0, 1'b1, 8'h03);
      n = 0;
      while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL abort_stop: busy=%b done=%b, required 0 0", busy, done);
      end
      dseen = 0;
      repeat (10) begin @(negedge clk); if (done) dseen++; end
      checks++;
      if (dseen !== 0 || mcnt !== 9'd1 || fail_valid !== 1'b1 || first_fail !== 8'h03) begin
         errors++; $display("FAIL abort_keep: dones=%0d cnt=%0d fv=%b ff=%h, required 0 1 1 03",
                            dseen, mcnt, fail_valid, first_fail);
      end
      start4(3'd0, 1'b0, 8'h00);
      checks++;
      if (mcnt !== 9'd0 || fail_valid !== 1'b0 || first_fail !== 8'h00 || busy !== 1'b1) begin
         errors++; $display("FAIL abort_restart: cnt=%0d fv=%b ff=%h busy=%b, required 0 0 00 1",
                            mcnt, fail_valid, first_fail, busy);
      end
      wait_done(400, n, d);
   endtask

   task automatic test_reset_mid;
      int n; int dseen; logic d;
      start4(3'd1, 1'b1, 8'h05);
      n = 0;
      while (busy === 1'b1 && n < 50) begin n++; @(negedge clk); end
      checks++;
      if (mcnt !== 9'd1) begin
         errors++; $display("FAIL rst_pre: cnt=%0d, required 1", mcnt);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || mcnt !== 9'd0 || cur_a !== 4'h0 || cur_b !== 4'h0 || fail_valid !== 1'b0) begin
         errors++; $display("FAIL rst_async: busy=%b cnt=%0d a=%h b=%h fv=%b, required 0 0 0 0 0",
                            busy, mcnt, cur_a, cur_b, fail_valid);
      end
      #3 rst_n = 1'b1;
      dseen = 0;
      repeat (300) begin @(negedge clk); if (done || busy) dseen++; end
      checks++;
      if (dseen !== 0) begin
         errors++; $display("FAIL rst_quiet: busy/done cycles=%0d, required 0", dseen);
      end
      start4(3'd7, 1'b0, 8'h00);
      wait_done(400, n, d);
      checks++;
      if (n !== 256 || d !== 1'b1 || mcnt !== 9'd0) begin
         errors++; $display("FAIL rst_resweep: cycles=%0d done=%b cnt=%0d, required 256 1 0", n, d, mcnt);
      end
   endtask

   initial begin
      test_reset;
      test_clean_sweep;
      test_inject;
      test_n1_nand;
      test_start_ignored;
      test_abort;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
